// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative dcache storage: tag-word layout and sweep FSM states.
package dcache_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Tag word is {valid, dirty, tag[TAG_W-1:0]}; positions depend on the instance's TAG_W.
  function automatic int unsigned valid_bit(input int unsigned tag_w);
    return tag_w + 32'd1;
  endfunction

  function automatic int unsigned dirty_bit(input int unsigned tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/dcache_lru_ages.sv
// Next-state age vector for one set under true-LRU: the accessed way becomes age 0,
// every way that was younger than it ages by one.
module dcache_lru_ages #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned AGE_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
  input  logic [AGE_W-1:0]           way_i,
  output logic [WAYS-1:0][AGE_W-1:0] ages_o
);

  always_comb begin
    ages_o = ages_i;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == way_i) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < ages_i[way_i]) begin
        ages_o[w] = ages_i[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data storage with true-LRU victim choice,
// invalidate-all sweep and saturating hit/miss counters. Lookup is combinational.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned TAG_W    = 23,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned IDX_W   = $clog2(NUM_SETS),
  localparam int unsigned AGE_W   = $clog2(WAYS),
  localparam int unsigned TW      = TAG_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TW-1:0]     tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              inv_i,
  output logic              busy_o,
  output logic [TW-1:0]     tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [AGE_W-1:0]  way_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned VALID_BIT = valid_bit(TAG_W);
  localparam int unsigned DIRTY_BIT = dirty_bit(TAG_W);

  logic [TW-1:0]              tag_q  [NUM_SETS][WAYS];
  logic [LINE_W-1:0]          data_q [NUM_SETS][WAYS];
  logic [WAYS-1:0][AGE_W-1:0] age_q  [NUM_SETS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic                       accepted;
  logic                       hit_any, inv_found;
  logic [AGE_W-1:0]           hit_way, inv_way, lru_way, sel_way;
  logic [WAYS-1:0][AGE_W-1:0] age_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_SWEEP: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(NUM_SETS - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (inv_i) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  assign busy_o   = (state_q == ST_SWEEP);
  assign accepted = enable_i & ~busy_o & ~inv_i;

  // Priority: hit way, then lowest invalid way, then the oldest (LRU) way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (tag_q[addr_i][w][VALID_BIT] &&
          (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!tag_q[addr_i][w][VALID_BIT] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
        lru_way = AGE_W'(w);
      end
    end
    sel_way = hit_any ? hit_way : (inv_found ? inv_way : lru_way);
  end

  assign tag_o  = accepted ? tag_q[addr_i][sel_way]  : '0;
  assign data_o = accepted ? data_q[addr_i][sel_way] : '0;
  assign hit_o  = accepted & hit_any;
  assign way_o  = accepted ? sel_way : '0;

  dcache_lru_ages #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_i (age_q[addr_i]),
    .way_i  (sel_way),
    .ages_o (age_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_SWEEP) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[ptr_q][w][VALID_BIT] <= 1'b0;
          tag_q[ptr_q][w][DIRTY_BIT] <= 1'b0;
          age_q[ptr_q][w]            <= AGE_W'(w);
        end
      end else if (accepted) begin
        age_q[addr_i] <= age_nxt;
        if (write_i) begin
          tag_q[addr_i][sel_way] <= tag_i;
        end
      end
    end
  end

  // Data array has no reset; contents survive both reset and invalidate sweeps.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accepted && write_i) begin
      data_q[addr_i][sel_way] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accepted) begin
      if (hit_any) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
